// File: rtl/nfc_apb_if.sv
`default_nettype none
// ============================================================================
//  Module   : nfc_apb_if
//  Purpose  : APB3 register front-end for a NAND flash controller. Holds the
//             command/address/length registers, launches operations through a
//             small FSM, and buffers write/read data in TX and RX byte FIFOs.
//  Revision : 1.0 - initial release
// ============================================================================
module nfc_apb_if #(
   parameter int FIFO_DEPTH = 16
) (
   input  logic        P_clk,
   input  logic        P_nrst,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [4:0]  PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   output logic [7:0]  C_Cmd0,
   output logic [7:0]  C_Cmd1,
   output logic [39:0] C_Addr,
   output logic [7:0]  C_Length,
   output logic        C_Start,
   input  logic        C_Busy,
   input  logic        C_Done,
   input  logic        C_WrReq,
   output logic [7:0]  C_WrData,
   input  logic        C_RdValid,
   input  logic [7:0]  C_RdData,
   output logic        IRQ
);
   localparam int c_AW = $clog2(FIFO_DEPTH);
   localparam int c_CW = c_AW + 1;
   localparam logic [c_CW-1:0] c_FULL = c_CW'(FIFO_DEPTH);

   localparam logic [2:0] c_CMD    = 3'd0;
   localparam logic [2:0] c_ADDRLO = 3'd1;
   localparam logic [2:0] c_ADDRHI = 3'd2;
   localparam logic [2:0] c_LEN    = 3'd3;
   localparam logic [2:0] c_CTRL   = 3'd4;
   localparam logic [2:0] c_STATUS = 3'd5;
   localparam logic [2:0] c_TXDATA = 3'd6;
   localparam logic [2:0] c_RXDATA = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2
   } state_t;

   state_t            r_state;
   logic              r_start, r_done, r_tx_ovf, r_rx_ovf, r_irqen, r_irq;
   logic [7:0]        r_cmd0, r_cmd1, r_len;
   logic [39:0]       r_addr;
   logic [7:0]        r_tx_mem [FIFO_DEPTH];
   logic [7:0]        r_rx_mem [FIFO_DEPTH];
   logic [c_AW-1:0]   r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
   logic [c_CW-1:0]   r_tx_cnt, r_rx_cnt;

   // Byte-lane offsets other than 0 select no register (read 0, no effect)
   logic       w_hit, w_wr, w_rd, w_busy, w_cfg_sel;
   logic [2:0] w_reg;
   assign w_hit     = (PADDR[1:0] == 2'b00);
   assign w_reg     = PADDR[4:2];
   assign w_wr      = PSEL & PENABLE & PWRITE & w_hit;
   assign w_rd      = PSEL & PENABLE & ~PWRITE & w_hit;
   assign w_busy    = (r_state != S_IDLE) | C_Busy;
   assign w_cfg_sel = (w_reg == c_CMD) | (w_reg == c_ADDRLO) |
                      (w_reg == c_ADDRHI) | (w_reg == c_LEN);

   logic w_cfg_wr, w_ctrl_wr, w_start_ok, w_start_err, w_txclr, w_rxclr, w_w1c;
   assign w_cfg_wr    = w_wr & w_cfg_sel & ~w_busy;
   assign w_ctrl_wr   = w_wr & (w_reg == c_CTRL);
   assign w_start_ok  = w_ctrl_wr & PWDATA[0] & (r_state == S_IDLE);
   assign w_start_err = w_ctrl_wr & PWDATA[0] & (r_state != S_IDLE);
   assign w_txclr     = w_ctrl_wr & PWDATA[1];
   assign w_rxclr     = w_ctrl_wr & PWDATA[2];
   assign w_w1c       = w_ctrl_wr & PWDATA[4];

   assign PREADY  = 1'b1;
   assign PSLVERR = (w_wr & w_cfg_sel & w_busy) | w_start_err |
                    (w_wr & ((w_reg == c_STATUS) | (w_reg == c_RXDATA))) |
                    (w_rd & (w_reg == c_TXDATA));

   // ---------------- TX FIFO (APB push, controller pop) ----------------
   logic w_tx_full, w_tx_empty, w_tx_req, w_tx_push, w_tx_pop;
   assign w_tx_full  = (r_tx_cnt == c_FULL);
   assign w_tx_empty = (r_tx_cnt == '0);
   assign w_tx_req   = w_wr & (w_reg == c_TXDATA);
   assign w_tx_pop   = C_WrReq & ~w_tx_empty;
   assign w_tx_push  = w_tx_req & (~w_tx_full | w_tx_pop);
   assign C_WrData   = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rp];

   // TX pointers and occupancy; clear overrides any same-cycle traffic
   always_ff @(posedge P_clk or negedge P_nrst) begin
      if (!P_nrst) begin
         r_tx_wp  <= '0;
         r_tx_rp  <= '0;
         r_tx_cnt <= '0;
      end else if (w_txclr) begin
         r_tx_wp  <= '0;
         r_tx_rp  <= '0;
         r_tx_cnt <= '0;
      end else begin
         if (w_tx_push) r_tx_wp <= r_tx_wp + c_AW'(1);
         if (w_tx_pop)  r_tx_rp <= r_tx_rp + c_AW'(1);
         if (w_tx_push & ~w_tx_pop)      r_tx_cnt <= r_tx_cnt + c_CW'(1);
         else if (~w_tx_push & w_tx_pop) r_tx_cnt <= r_tx_cnt - c_CW'(1);
      end
   end

   // TX storage; contents are only visible while the entry is occupied
   always_ff @(posedge P_clk) begin
      if (w_tx_push & ~w_txclr) r_tx_mem[r_tx_wp] <= PWDATA[7:0];
   end

   // ---------------- RX FIFO (controller push, APB pop) ----------------
   logic       w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;
   logic [7:0] w_rx_head;
   assign w_rx_full  = (r_rx_cnt == c_FULL);
   assign w_rx_empty = (r_rx_cnt == '0);
   assign w_rx_pop   = w_rd & (w_reg == c_RXDATA) & ~w_rx_empty;
   assign w_rx_push  = C_RdValid & (~w_rx_full | w_rx_pop);
   assign w_rx_head  = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp];

   // RX pointers and occupancy; clear overrides any same-cycle traffic
   always_ff @(posedge P_clk or negedge P_nrst) begin
      if (!P_nrst) begin
         r_rx_wp  <= '0;
         r_rx_rp  <= '0;
         r_rx_cnt <= '0;
      end else if (w_rxclr) begin
         r_rx_wp  <= '0;
         r_rx_rp  <= '0;
         r_rx_cnt <= '0;
      end else begin
         if (w_rx_push) r_rx_wp <= r_rx_wp + c_AW'(1);
         if (w_rx_pop)  r_rx_rp <= r_rx_rp + c_AW'(1);
         if (w_rx_push & ~w_rx_pop)      r_rx_cnt <= r_rx_cnt + c_CW'(1);
         else if (~w_rx_push & w_rx_pop) r_rx_cnt <= r_rx_cnt - c_CW'(1);
      end
   end

   // RX storage
   always_ff @(posedge P_clk) begin
      if (w_rx_push & ~w_rxclr) r_rx_mem[r_rx_wp] <= C_RdData;
   end

   // Operation FSM with registered launch pulse and sticky done
   always_ff @(posedge P_clk or negedge P_nrst) begin
      if (!P_nrst) begin
         r_state <= S_IDLE;
         r_start <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start_ok) begin
                  r_state <= S_LAUNCH;
                  r_start <= 1'b1;
               end
            end
            S_LAUNCH: begin
               r_state <= S_WAIT;
               r_start <= 1'b0;
            end
            S_WAIT: begin
               if (C_Done) r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_start <= 1'b0;
            end
         endcase
         if ((r_state == S_WAIT) && C_Done) r_done <= 1'b1;
         else if (w_start_ok || w_w1c)      r_done <= 1'b0;
      end
   end

   // Configuration registers, frozen while an operation is in flight
   always_ff @(posedge P_clk or negedge P_nrst) begin
      if (!P_nrst) begin
         r_cmd0 <= '0;
         r_cmd1 <= '0;
         r_addr <= '0;
         r_len  <= '0;
      end else if (w_cfg_wr) begin
         case (w_reg)
            c_CMD:    begin r_cmd0 <= PWDATA[7:0]; r_cmd1 <= PWDATA[15:8]; end
            c_ADDRLO: r_addr[31:0]  <= PWDATA;
            c_ADDRHI: r_addr[39:32] <= PWDATA[7:0];
            c_LEN:    r_len <= PWDATA[7:0];
            default:  ;
         endcase
      end
   end

   // Sticky overflow flags, interrupt enable and registered interrupt
   always_ff @(posedge P_clk or negedge P_nrst) begin
      if (!P_nrst) begin
         r_tx_ovf <= 1'b0;
         r_rx_ovf <= 1'b0;
         r_irqen  <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         if (w_tx_req & w_tx_full & ~w_tx_pop & ~w_txclr) r_tx_ovf <= 1'b1;
         else if (w_w1c)                                  r_tx_ovf <= 1'b0;
         if (C_RdValid & w_rx_full & ~w_rx_pop & ~w_rxclr) r_rx_ovf <= 1'b1;
         else if (w_w1c)                                   r_rx_ovf <= 1'b0;
         if (w_ctrl_wr) r_irqen <= PWDATA[3];
         r_irq <= r_irqen & (r_done | r_tx_ovf | r_rx_ovf);
      end
   end

   logic [31:0] w_status;
   assign w_status = {8'h00,
                      {(8-c_CW){1'b0}}, r_rx_cnt,
                      {(8-c_CW){1'b0}}, r_tx_cnt,
                      r_rx_ovf, r_tx_ovf, w_rx_empty, w_rx_full,
                      w_tx_empty, w_tx_full, r_done, w_busy};

   // Read mux, driven only while the slave is selected for a read
   always_comb begin
      PRDATA = 32'h0;
      if (PSEL & ~PWRITE & w_hit) begin
         case (w_reg)
            c_CMD:    PRDATA = {16'h0, r_cmd1, r_cmd0};
            c_ADDRLO: PRDATA = r_addr[31:0];
            c_ADDRHI: PRDATA = {24'h0, r_addr[39:32]};
            c_LEN:    PRDATA = {24'h0, r_len};
            c_CTRL:   PRDATA = {28'h0, r_irqen, 3'b000};
            c_STATUS: PRDATA = w_status;
            c_RXDATA: PRDATA = {24'h0, w_rx_head};
            default:  PRDATA = 32'h0;
         endcase
      end
   end

   assign C_Cmd0   = r_cmd0;
   assign C_Cmd1   = r_cmd1;
   assign C_Addr   = r_addr;
   assign C_Length = r_len;
   assign C_Start  = r_start;
   assign IRQ      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_nfc_apb_if.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nfc_apb_if
//  Purpose  : Directed self-checking bench for nfc_apb_if (FIFO_DEPTH = 16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nfc_apb_if;
   logic        P_clk = 1'b0;
   logic        P_nrst = 1'b0;
   logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [4:0]  PADDR = '0;
   logic [31:0] PWDATA = '0;
   logic [31:0] PRDATA;
   logic        PREADY, PSLVERR;
   logic [7:0]  C_Cmd0, C_Cmd1, C_Length, C_WrData;
   logic [39:0] C_Addr;
   logic        C_Start, IRQ;
   logic        C_Busy = 1'b0, C_Done = 1'b0, C_WrReq = 1'b0, C_RdValid = 1'b0;
   logic [7:0]  C_RdData = '0;

   int checks = 0;
   int failures = 0;
   int start_cnt = 0;

   nfc_apb_if #(.FIFO_DEPTH(16)) dut (
      .P_clk(P_clk), .P_nrst(P_nrst),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .C_Cmd0(C_Cmd0), .C_Cmd1(C_Cmd1), .C_Addr(C_Addr), .C_Length(C_Length),
      .C_Start(C_Start), .C_Busy(C_Busy), .C_Done(C_Done),
      .C_WrReq(C_WrReq), .C_WrData(C_WrData),
      .C_RdValid(C_RdValid), .C_RdData(C_RdData), .IRQ(IRQ)
   );

   always #5 P_clk = ~P_clk;

   // Count clock edges at which the launch pulse is high
   always @(posedge P_clk) if (C_Start === 1'b1) start_cnt = start_cnt + 1;

   // All tasks start and end 1 time unit after a rising edge
   task automatic apb_write(input logic [4:0] a, input logic [31:0] d, output logic err);
      PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
      @(posedge P_clk); #1;
      PENABLE = 1'b1; #1;
      err = PSLVERR;
      @(posedge P_clk); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [4:0] a, output logic [31:0] d, output logic err);
      PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
      @(posedge P_clk); #1;
      PENABLE = 1'b1; #1;
      d = PRDATA; err = PSLVERR;
      @(posedge P_clk); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic pulse_done();
      @(posedge P_clk); #1;
      C_Done = 1'b1;
      @(posedge P_clk); #1;
      C_Done = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d; logic e;
      P_nrst = 1'b0;
      repeat (3) @(posedge P_clk); #1;
      checks++; if (C_Start !== 1'b0 || IRQ !== 1'b0 || PRDATA !== 32'h0) begin
         failures++; $display("FAIL reset_outs start=%b irq=%b prdata=%h required 0/0/0", C_Start, IRQ, PRDATA); end
      P_nrst = 1'b1;
      @(posedge P_clk); #1;
      checks++; if ({C_Cmd0, C_Cmd1, C_Length} !== 24'h0 || C_Addr !== 40'h0) begin
         failures++; $display("FAIL reset_cfg cmd0=%h cmd1=%h len=%h addr=%h required 0", C_Cmd0, C_Cmd1, C_Length, C_Addr); end
      apb_read(5'h14, d, e);
      checks++; if (d !== 32'h28) begin
         failures++; $display("FAIL reset_status got=%h required=%h", d, 32'h28); end
   endtask

   task automatic test_operation();
      logic [31:0] d; logic e; int s0;
      apb_write(5'h00, 32'h3000, e);
      apb_write(5'h04, 32'h04030201, e);
      apb_write(5'h08, 32'h05, e);
      apb_write(5'h0C, 32'h04, e);
      checks++; if (C_Cmd0 !== 8'h00 || C_Cmd1 !== 8'h30 || C_Addr !== 40'h0504030201 || C_Length !== 8'h04) begin
         failures++; $display("FAIL op_cfg cmd0=%h cmd1=%h addr=%h len=%h required 00/30/0504030201/04", C_Cmd0, C_Cmd1, C_Addr, C_Length); end
      s0 = start_cnt;
      apb_write(5'h10, 32'h1, e);
      checks++; if (e !== 1'b0 || C_Start !== 1'b1) begin
         failures++; $display("FAIL op_launch err=%b start=%b required 0/1", e, C_Start); end
      apb_read(5'h14, d, e);
      checks++; if (d !== 32'h29) begin
         failures++; $display("FAIL op_busy_status got=%h required=%h", d, 32'h29); end
      checks++; if (start_cnt - s0 !== 1) begin
         failures++; $display("FAIL op_start_pulses got=%0d required=1", start_cnt - s0); end
      pulse_done();
      apb_read(5'h14, d, e);
      checks++; if (d !== 32'h2A) begin
         failures++; $display("FAIL op_done_status got=%h required=%h", d, 32'h2A); end
   endtask

   task automatic test_tx_fifo();
      logic [31:0] d; logic e;
      apb_write(5'h10, 32'h10, e);
      for (int i = 1; i <= 17; i++) apb_write(5'h18, i, e);
      apb_read(5'h14, d, e);
      checks++; if (d !== 32'h1064) begin
         failures++; $display("FAIL tx_full_status got=%h required=%h", d, 32'h1064); end
      for (int i = 1; i <= 16; i++) begin
         C_WrReq = 1'b1;
         checks++; if (C_WrData !== 8'(i)) begin
            failures++; $display("FAIL tx_pop_data idx=%0d got=%h required=%h", i, C_WrData, 8'(i)); end
         @(posedge P_clk); #1;
      end
      C_WrReq = 1'b1;
      checks++; if (C_WrData !== 8'h00) begin
         failures++; $display("FAIL tx_empty_data got=%h required=00", C_WrData); end
      @(posedge P_clk); #1;
      C_WrReq = 1'b0;
      apb_read(5'h14, d, e);
      checks++; if (d !== 32'h68) begin
         failures++; $display("FAIL tx_drained_status got=%h required=%h", d, 32'h68); end
      apb_write(5'h10, 32'h10, e);
      for (int i = 0; i < 3; i++) apb_write(5'h18, 32'hB1 + i, e);
      apb_read(5'h14, d, e);
      checks++; if (d !== 32'h0320 || C_WrData !== 8'hB1) begin
         failures++; $display("FAIL tx_three status=%h head=%h required 00000320/b1", d, C_WrData); end
      apb_write(5'h10, 32'h2, e);
      apb_read(5'h14, d, e);
      checks++; if (d !== 32'h28) begin
         failures++; $display("FAIL tx_clear_status got=%h required=%h", d, 32'h28); end
   endtask

   task automatic test_rx_fifo();
      logic [31:0] d; logic e;
      logic [7:0] exp_b [4] = '{8'hA1, 8'hA2, 8'hA3, 8'h00};
      for (int i = 0; i < 3; i++) begin
         C_RdValid = 1'b1; C_RdData = exp_b[i];
         @(posedge P_clk); #1;
      end
      C_RdValid = 1'b0;
      apb_read(5'h14, d, e);
      checks++; if (d !== 32'h00030008) begin
         failures++; $display("FAIL rx_count_status got=%h required=%h", d, 32'h00030008); end
      for (int i = 0; i < 4; i++) begin
         apb_read(5'h1C, d, e);
         checks++; if (d !== {24'h0, exp_b[i]} || e !== 1'b0) begin
            failures++; $display("FAIL rx_read idx=%0d got=%h err=%b required=%h err=0", i, d, e, exp_b[i]); end
      end
      apb_read(5'h14, d, e);
      checks++; if (d !== 32'h28) begin
         failures++; $display("FAIL rx_empty_status got=%h required=%h", d, 32'h28); end
   endtask

   task automatic test_busy_errors();
      logic [31:0] d; logic e; int s0;
      apb_write(5'h10, 32'h1, e);
      apb_write(5'h0C, 32'h55, e);
      checks++; if (e !== 1'b1) begin
         failures++; $display("FAIL busy_len_err got=%b required=1", e); end
      apb_read(5'h0C, d, e);
      checks++; if (d !== 32'h04 || C_Length !== 8'h04) begin
         failures++; $display("FAIL busy_len_kept got=%h pin=%h required=04", d, C_Length); end
      s0 = start_cnt;
      apb_write(5'h10, 32'h1, e);
      checks++; if (e !== 1'b1) begin
         failures++; $display("FAIL busy_start_err got=%b required=1", e); end
      pulse_done();
      checks++; if (start_cnt - s0 !== 0) begin
         failures++; $display("FAIL busy_start_pulses got=%0d required=0", start_cnt - s0); end
      C_Busy = 1'b1;
      apb_read(5'h14, d, e);
      checks++; if (d !== 32'h2B) begin
         failures++; $display("FAIL cbusy_status got=%h required=%h", d, 32'h2B); end
      apb_write(5'h00, 32'h1234, e);
      checks++; if (e !== 1'b1 || C_Cmd1 !== 8'h30) begin
         failures++; $display("FAIL cbusy_cmd err=%b cmd1=%h required 1/30", e, C_Cmd1); end
      C_Busy = 1'b0;
      apb_write(5'h14, 32'h0, e);
      checks++; if (e !== 1'b1) begin
         failures++; $display("FAIL wr_status_err got=%b required=1", e); end
      apb_read(5'h18, d, e);
      checks++; if (e !== 1'b1) begin
         failures++; $display("FAIL rd_txdata_err got=%b required=1", e); end
      apb_write(5'h1C, 32'h0, e);
      checks++; if (e !== 1'b1) begin
         failures++; $display("FAIL wr_rxdata_err got=%b required=1", e); end
   endtask

   task automatic test_irq();
      logic [31:0] d; logic e;
      apb_write(5'h10, 32'h18, e);
      apb_read(5'h10, d, e);
      checks++; if (d !== 32'h08) begin
         failures++; $display("FAIL irq_ctrl_rd got=%h required=%h", d, 32'h08); end
      @(posedge P_clk); #1;
      checks++; if (IRQ !== 1'b0) begin
         failures++; $display("FAIL irq_idle got=%b required=0", IRQ); end
      apb_write(5'h10, 32'h9, e);
      pulse_done();
      @(posedge P_clk); #1;
      checks++; if (IRQ !== 1'b1) begin
         failures++; $display("FAIL irq_set got=%b required=1", IRQ); end
      apb_write(5'h10, 32'h18, e);
      @(posedge P_clk); #1;
      checks++; if (IRQ !== 1'b0) begin
         failures++; $display("FAIL irq_clear got=%b required=0", IRQ); end
      apb_read(5'h14, d, e);
      checks++; if (d !== 32'h28) begin
         failures++; $display("FAIL irq_w1c_status got=%h required=%h", d, 32'h28); end
   endtask

   task automatic test_reset_in_wait();
      logic [31:0] d; logic e; int s0;
      for (int i = 0; i < 5; i++) apb_write(5'h18, i + 1, e);
      apb_write(5'h10, 32'h1, e);
      @(posedge P_clk); #1;
      s0 = start_cnt;
      P_nrst = 1'b0; #1;
      checks++; if (C_Start !== 1'b0 || IRQ !== 1'b0 || C_Addr !== 40'h0) begin
         failures++; $display("FAIL rst_wait_outs start=%b irq=%b addr=%h required 0", C_Start, IRQ, C_Addr); end
      repeat (2) @(posedge P_clk); #1;
      P_nrst = 1'b1;
      @(posedge P_clk); #1;
      C_Done = 1'b1;
      @(posedge P_clk); #1;
      C_Done = 1'b0;
      apb_read(5'h14, d, e);
      checks++; if (d !== 32'h28) begin
         failures++; $display("FAIL rst_wait_status got=%h required=%h", d, 32'h28); end
      repeat (4) @(posedge P_clk); #1;
      checks++; if (start_cnt - s0 !== 0) begin
         failures++; $display("FAIL rst_wait_pulses got=%0d required=0", start_cnt - s0); end
      apb_read(5'h10, d, e);
      checks++; if (d !== 32'h0) begin
         failures++; $display("FAIL rst_wait_ctrl got=%h required=0", d); end
   endtask

   initial begin
      test_reset();
      test_operation();
      test_tx_fifo();
      test_rx_fifo();
      test_busy_errors();
      test_irq();
      test_reset_in_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
